// File: rtl/display_pkg.sv
// Shared types and default geometry for the display capture block.
package display_pkg;

    localparam int unsigned DEF_ACTIVE_PIXELS = 640;
    localparam int unsigned DEF_ACTIVE_LINES  = 480;
    localparam int unsigned PIXELS_PER_WORD   = 4;
    localparam int unsigned LANE_W            = $clog2(PIXELS_PER_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FRAME = 2'd2,
        DONE  = 2'd3
    } cap_state_e;

endpackage

// File: rtl/display_capture_pixel_packer.sv
// Gathers accepted pixels into little-endian words and issues one-cycle
// frame-buffer writes with an auto-incrementing word address.
module pixel_packer
    import display_pkg::*;
#(
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned ADDR_LAST = 76799
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             restart,
    input  logic                             discard,
    input  logic                             pix_store,
    input  logic [PIX_W-1:0]                 pix_in,
    output logic                             wr_en,
    output logic [ADDR_W-1:0]                wr_addr,
    output logic [PIX_W*PIXELS_PER_WORD-1:0] wr_data
);

    logic [PIXELS_PER_WORD-1:0][PIX_W-1:0] lanes_q, lanes_d;
    logic [LANE_W-1:0]                     lane_q, lane_d;
    logic [ADDR_W-1:0]                     next_addr_q, next_addr_d;
    logic [ADDR_W-1:0]                     wr_addr_q, wr_addr_d;
    logic [PIX_W*PIXELS_PER_WORD-1:0]      wr_data_q, wr_data_d;
    logic                                  wr_en_q, wr_en_d;

    // Lane fill and word emission; restart wins over discard wins over store.
    always_comb begin
        lanes_d     = lanes_q;
        lane_d      = lane_q;
        next_addr_d = next_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        if (restart) begin
            lane_d      = '0;
            next_addr_d = '0;
            wr_addr_d   = '0;
        end else if (discard) begin
            lane_d = '0;
        end else if (pix_store) begin
            lanes_d[lane_q] = pix_in;
            if (lane_q == LANE_W'(PIXELS_PER_WORD - 1)) begin
                lane_d    = '0;
                wr_en_d   = 1'b1;
                wr_data_d = lanes_d;
                wr_addr_d = next_addr_q;
                if (next_addr_q != ADDR_W'(ADDR_LAST)) begin
                    next_addr_d = next_addr_q + ADDR_W'(1);
                end
            end else begin
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lanes_q     <= '0;
            lane_q      <= '0;
            next_addr_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
        end else begin
            lanes_q     <= lanes_d;
            lane_q      <= lane_d;
            next_addr_q <= next_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: rtl/display_capture.sv
// Display receive-side frame grabber: FSM, geometry checks and packing.
// Optional frame checksum enabled by defining CAPTURE_CHECKSUM_EN.
module display_capture
    import display_pkg::*;
#(
    parameter int unsigned ACTIVE_PIXELS = DEF_ACTIVE_PIXELS,
    parameter int unsigned ACTIVE_LINES  = DEF_ACTIVE_LINES,
    parameter int unsigned PIX_W         = 8,
    parameter int unsigned ADDR_W        = 17
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             capture_en,
    input  logic                             vblank,
    input  logic                             hblank,
    input  logic                             pix_valid,
    input  logic [PIX_W-1:0]                 pix_in,
    output logic                             wr_en,
    output logic [ADDR_W-1:0]                wr_addr,
    output logic [PIX_W*PIXELS_PER_WORD-1:0] wr_data,
    output logic                             frame_done,
    output logic [7:0]                       frame_count,
    output logic                             line_err,
    output logic                             frame_err,
    output logic [PIX_W*PIXELS_PER_WORD-1:0] frame_sum
);

    localparam int unsigned DATA_W    = PIX_W * PIXELS_PER_WORD;
    localparam int unsigned X_W       = $clog2(ACTIVE_PIXELS + 1);
    localparam int unsigned Y_W       = $clog2(ACTIVE_LINES + 2);
    localparam int unsigned ADDR_LAST = (ACTIVE_PIXELS * ACTIVE_LINES) / PIXELS_PER_WORD - 1;

    cap_state_e     state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           hblank_q;
    logic           line_err_q, line_err_d;
    logic           frame_err_q, frame_err_d;
    logic           frame_done_q, frame_done_d;
    logic [7:0]     frame_count_q, frame_count_d;

    logic accept_c, x_ok_c, y_ok_c, store_c, eol_c, restart_c;

    assign accept_c  = (state_q == FRAME) && pix_valid && !hblank && !vblank;
    assign x_ok_c    = x_q < X_W'(ACTIVE_PIXELS);
    assign y_ok_c    = y_q < Y_W'(ACTIVE_LINES);
    assign store_c   = accept_c && x_ok_c && y_ok_c;
    // A line ends on hblank rising, but only once it has carried a pixel.
    assign eol_c     = (state_q == FRAME) && hblank && !hblank_q && (x_q != '0);
    assign restart_c = (state_d == ARMED);

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        line_err_d    = line_err_q;
        frame_err_d   = frame_err_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        unique case (state_q)
            IDLE: begin
                if (capture_en && vblank) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                x_d = '0;
                y_d = '0;
                if (!vblank) begin
                    state_d     = FRAME;
                    line_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            FRAME: begin
                if (accept_c) begin
                    if (x_ok_c) begin
                        x_d = x_q + X_W'(1);
                    end else begin
                        line_err_d = 1'b1;
                    end
                    if (!y_ok_c) begin
                        frame_err_d = 1'b1;
                    end
                end
                if (eol_c) begin
                    if (x_q != X_W'(ACTIVE_PIXELS)) begin
                        line_err_d = 1'b1;
                    end
                    x_d = '0;
                    if (y_q != Y_W'(ACTIVE_LINES + 1)) begin
                        y_d = y_q + Y_W'(1);
                    end
                end
                // Outputs for the DONE cycle are loaded on the way in.
                if (vblank) begin
                    state_d       = DONE;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                    if (y_d != Y_W'(ACTIVE_LINES)) begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = capture_en ? ARMED : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            hblank_q      <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hblank_q      <= hblank;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    pixel_packer #(
        .PIX_W     (PIX_W),
        .ADDR_W    (ADDR_W),
        .ADDR_LAST (ADDR_LAST)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart_c),
        .discard   (eol_c),
        .pix_store (store_c),
        .pix_in    (pix_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

`ifdef CAPTURE_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] frame_sum_q, frame_sum_d;

    // Running sum of written words, published when the frame closes.
    always_comb begin
        acc_d       = acc_q;
        frame_sum_d = frame_sum_q;
        if (wr_en) begin
            acc_d = acc_q + wr_data;
        end
        if (state_q == ARMED) begin
            acc_d = '0;
        end
        if ((state_q == FRAME) && (state_d == DONE)) begin
            frame_sum_d = acc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            acc_q       <= acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`else
    assign frame_sum = DATA_W'(0);
`endif

    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture with a write scoreboard (8x2 geometry).
module tb_display_capture;

    localparam int AP     = 8;
    localparam int AL     = 2;
    localparam int ADDR_W = 17;

    logic              clk        = 1'b0;
    logic              reset      = 1'b0;
    logic              capture_en = 1'b0;
    logic              vblank     = 1'b0;
    logic              hblank     = 1'b0;
    logic              pix_valid  = 1'b0;
    logic [7:0]        pix_in     = 8'h00;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              frame_done;
    logic [7:0]        frame_count;
    logic              line_err;
    logic              frame_err;
    logic [31:0]       frame_sum;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_exp_t;

    wr_exp_t           sb[$];
    int                tests = 0;
    int                fails = 0;
    int                cyc   = 0;
    bit                model_on = 1'b1;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [31:0]       m_word = '0;
    logic [31:0]       m_sum  = '0;

    display_capture #(
        .ACTIVE_PIXELS (AP),
        .ACTIVE_LINES  (AL),
        .PIX_W         (8),
        .ADDR_W        (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .capture_en  (capture_en),
        .vblank      (vblank),
        .hblank      (hblank),
        .pix_valid   (pix_valid),
        .pix_in      (pix_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .line_err    (line_err),
        .frame_err   (frame_err),
        .frame_sum   (frame_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog: simulation did not finish, expected completion");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every write must match the oldest expected write, including its cycle.
    always @(negedge clk) begin
        wr_exp_t e;
        if (reset === 1'b1 && wr_en !== 1'b0) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_write: got addr 0x%05h data 0x%08h expected no write", wr_addr, wr_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", wr_data, e.data);
                check("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic open_frame();
        @(negedge clk);
        vblank = 1'b1; hblank = 1'b1; pix_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vblank = 1'b0;
        @(negedge clk);
        m_addr = '0;
        m_sum  = '0;
    endtask

    task automatic drive_line(input int n, input logic [7:0] base, input int line_idx, input bit close);
        wr_exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hblank = 1'b0; pix_valid = 1'b1; pix_in = base + 8'(i);
            if (model_on && i < AP && line_idx < AL) begin
                m_word[8*(i%4) +: 8] = pix_in;
                if (i % 4 == 3) begin
                    e.addr = m_addr; e.data = m_word; e.cyc = cyc + 1;
                    sb.push_back(e);
                    m_sum  = m_sum + m_word;
                    m_addr = m_addr + 1'b1;
                end
            end
        end
        if (close) begin
            @(negedge clk);
            hblank = 1'b1; pix_valid = 1'b1; pix_in = 8'hEE;
            @(negedge clk);
            pix_valid = 1'b0;
        end
    endtask

    task automatic close_frame(input logic [7:0] exp_count, input bit exp_lerr, input bit exp_ferr,
                               input bit pix_on_vblank);
        bit          seen;
        logic [31:0] exp_sum;
        @(negedge clk);
        vblank = 1'b1; hblank = !pix_on_vblank; pix_valid = pix_on_vblank; pix_in = 8'h77;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            pix_valid = 1'b0; hblank = 1'b1;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        tests++;
        assert (seen) else begin
            fails++;
            $error("FAIL frame_done_timeout: got no pulse expected pulse within 20 cycles");
        end
`ifdef CAPTURE_CHECKSUM_EN
        exp_sum = m_sum;
`else
        exp_sum = 32'h0;
`endif
        if (seen) begin
            check("frame_count", 32'(frame_count), 32'(exp_count));
            check("line_err", 32'(line_err), 32'(exp_lerr));
            check("frame_err", 32'(frame_err), 32'(exp_ferr));
            check("frame_sum", frame_sum, exp_sum);
            check("writes_pending", 32'(sb.size()), 32'd0);
            @(negedge clk);
            check("frame_done_once", 32'(frame_done), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, wr_data, 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        check({tag, "_line_err"}, 32'(line_err), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_frame_sum"}, frame_sum, 32'd0);
    endtask

    initial begin
        // Reset held with random inputs.
        repeat (6) begin
            @(negedge clk);
            capture_en = 1'($urandom); vblank = 1'($urandom); hblank = 1'($urandom);
            pix_valid = 1'($urandom); pix_in = 8'($urandom);
        end
        check_all_zero("reset");

        // Released without capture_en: no writes may appear.
        @(negedge clk);
        capture_en = 1'b0; reset = 1'b1;
        repeat (12) begin
            @(negedge clk);
            vblank = 1'($urandom); hblank = 1'($urandom);
            pix_valid = 1'($urandom); pix_in = 8'($urandom);
        end
        @(negedge clk);
        vblank = 1'b0; hblank = 1'b0; pix_valid = 1'b0;
        check("idle_wr_en", 32'(wr_en), 32'd0);
        check("idle_frame_count", 32'(frame_count), 32'd0);

        // Nominal frame.
        capture_en = 1'b1;
        open_frame();
        drive_line(8, 8'h00, 0, 1'b1);
        drive_line(8, 8'h10, 1, 1'b1);
        close_frame(8'd1, 1'b0, 1'b0, 1'b0);

        // Short line then long line.
        open_frame();
        drive_line(6, 8'h20, 0, 1'b1);
        drive_line(10, 8'h30, 1, 1'b1);
        close_frame(8'd2, 1'b1, 1'b0, 1'b0);

        // Three lines: third is dropped and flagged.
        open_frame();
        drive_line(8, 8'hC0, 0, 1'b1);
        drive_line(8, 8'hD0, 1, 1'b1);
        drive_line(8, 8'hE0, 2, 1'b1);
        close_frame(8'd3, 1'b0, 1'b1, 1'b0);

        // Clean frame clears errors and restarts addressing.
        open_frame();
        check("rearm_wr_addr", 32'(wr_addr), 32'd0);
        check("rearm_line_err", 32'(line_err), 32'd0);
        check("rearm_frame_err", 32'(frame_err), 32'd0);
        drive_line(8, 8'h40, 0, 1'b1);
        drive_line(8, 8'h50, 1, 1'b1);
        close_frame(8'd4, 1'b0, 1'b0, 1'b0);

        // Pixel coincident with vblank rising is ignored.
        open_frame();
        drive_line(8, 8'h60, 0, 1'b1);
        drive_line(7, 8'h70, 1, 1'b0);
        close_frame(8'd5, 1'b0, 1'b1, 1'b1);

        // capture_en dropped mid-frame: frame finishes, then nothing more.
        open_frame();
        drive_line(8, 8'h80, 0, 1'b1);
        capture_en = 1'b0;
        drive_line(8, 8'h90, 1, 1'b1);
        close_frame(8'd6, 1'b0, 1'b0, 1'b0);
        model_on = 1'b0;
        open_frame();
        drive_line(8, 8'hA0, 0, 1'b1);
        drive_line(8, 8'hA8, 1, 1'b1);
        @(negedge clk);
        vblank = 1'b1;
        tick(4);
        check("disarmed_frame_count", 32'(frame_count), 32'd6);
        model_on = 1'b1;

        // Reset pulsed mid-line, on the cycle that would complete a word.
        capture_en = 1'b1;
        open_frame();
        drive_line(3, 8'hB0, 0, 1'b0);
        check("pre_reset_frame_count", 32'(frame_count), 32'd6);
        @(negedge clk);
        pix_valid = 1'b1; pix_in = 8'hB3;
        #2 reset = 1'b0;
        #1 check_all_zero("midline_reset");
        tick(3);
        capture_en = 1'b0; vblank = 1'b0; hblank = 1'b0; pix_valid = 1'b0;
        reset = 1'b1;
        tick(6);
        check("post_reset_wr_en", 32'(wr_en), 32'd0);
        check("post_reset_pending", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
